des_key_schedule: RTL and testbench
===================================

Name: des_key_schedule

Overview:
- Generates the sixteen 48-bit DES round subkeys from a 64-bit key, one subkey per handshake.
- Sits upstream of the round function. Each subkey is XORed with E(R), and the result is split into the eight 6-bit S-box inputs (S1..S8).
- Supports encryption order (K1..K16) and decryption order (K16..K1), so the round datapath needs no key reversal.

Parameters:
- None. Round count (16), shift schedule and PC-1/PC-2 tables are fixed per FIPS 46-3.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- key_in  in  [1:64]  DES key, bit 1 = MSB (FIPS numbering); parity bits 8,16,..,64 ignored
- decrypt  in  1  0 = encrypt order, 1 = decrypt order; sampled only on key accept
- key_valid  in  1  key_in/decrypt valid
- key_ready  out  1  block idle, can accept a key
- subkey  out  [1:48]  current round subkey, bit 1 = MSB
- subkey_round  out  4  round index 0..15 (0 = first subkey issued, not the K number)
- subkey_valid  out  1  subkey/subkey_round valid
- subkey_ready  in  1  consumer accepts subkey
- subkey_last  out  1  high with subkey_valid on the 16th subkey

Behaviour:
- Registers: C[1:28], D[1:28], round[3:0], mode, state ∈ {IDLE, RUN}.
- Outputs are decoded from registers only; there is no combinational path from any input to any output.
- Reset (sync): state=IDLE, C=D=0, round=0, mode=0.
  - Outputs: key_ready=1, subkey_valid=0, subkey_last=0, subkey_round=0, subkey=PC-2(0)=48'h0.
- key_ready = (state==IDLE).
- subkey_valid = (state==RUN).
- subkey = PC-2(C||D).
- subkey_round = round.
- subkey_last = (state==RUN && round==15).
- Shift schedule S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- IDLE, when key_valid=1: accept and go to RUN next cycle. Load C0||D0 = PC-1(key_in), set mode=decrypt, round=0, then:
  - encrypt: C,D = C0,D0 rotated left by S[1] (so C1,D1);
  - decrypt: C,D = C0,D0 unrotated (equals C16,D16, since total shift = 28).
- First subkey is valid the cycle after the accept (latency 1).
- RUN, subkey_valid && subkey_ready:
  - round<15: round+1, and C,D each rotate independently by S[n]:
    - encrypt: left by S[round+2];
    - decrypt: right by S[17-(round+1)], i.e. right shifts 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 for transitions 0→1..14→15.
  - round==15: state=IDLE, round=0, C,D held. key_ready=1 the next cycle (no same-cycle key accept on the last handshake).
- RUN, subkey_ready=0: all registers hold; subkey, subkey_round and subkey_last stay stable (AXI-style: valid never drops without a handshake).
- key_valid is ignored while key_ready=0; key_in and decrypt may change freely in RUN.
- Throughput: 16 subkeys in 16 cycles at full ready, plus 1 idle cycle, so 17 cycles per key.
- rst asserted mid-RUN: next cycle is the full reset state; any partial key sequence is abandoned and no further subkey_valid appears.
- Rotations are within the 28-bit C and D halves separately; the bit shifted out of position 1 re-enters at position 28 (left), and vice versa for right.

Test Plan:
- Reset check: assert rst, then release → key_ready=1, subkey_valid=0, subkey_round=0, subkey=0.
- Encrypt vector: key_in=64'h133457799BBCDFF1, decrypt=0, subkey_ready=1 → internal C0=28'hF0CCAAF, D0=28'h556678F. Subkeys:
  - round 0 = 48'h1B02EFFC7072;
  - round 15 = 48'hCB3D8B0E17F5 with subkey_last=1;
  - key_ready=1 the cycle after.
- Decrypt vector: same key, decrypt=1 → round 0 = 48'hCB3D8B0E17F5, round 15 = 48'h1B02EFFC7072. All 16 subkeys equal the encrypt sequence reversed.
- Backpressure: encrypt run with subkey_ready low for 5 cycles at round 3 → subkey/round stable throughout; the sequence resumes with no skip or repeat; 16 handshakes total.
- Parity/busy: key_in=64'h123456789ABCDEF0 → identical subkeys to the same key with all parity bits flipped. A key_valid pulse during RUN is ignored: sequence unchanged, no second run.
- Mid-run reset: rst at round 7 → next cycle key_ready=1, subkey_valid=0. A new key accepted after reset produces a clean full 16-subkey sequence matching the reference values.

Source files
------------

// File: rtl/des_key_schedule.sv
// DES key schedule: expands a 64-bit key into the sixteen 48-bit round subkeys,
// one per valid/ready handshake, in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:64] key_in,
    input  logic        decrypt,
    input  logic        key_valid,
    output logic        key_ready,
    output logic [1:48] subkey,
    output logic [3:0]  subkey_round,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic        subkey_last
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [1:56] pc1(input logic [1:64] k);
        logic [1:56] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[i+1] = k[PC1[i]];
        return r;
    endfunction

    function automatic logic [1:48] pc2(input logic [1:56] cd);
        logic [1:48] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[i+1] = cd[PC2[i]];
        return r;
    endfunction

    function automatic logic [1:28] rotl(input logic [1:28] x, input logic two);
        return two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
    endfunction

    function automatic logic [1:28] rotr(input logic [1:28] x, input logic two);
        return two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
    endfunction

    // Shift schedule S[1..16]: single shifts at 1, 2, 9 and 16, double elsewhere.
    function automatic logic shift_two(input logic [4:0] idx);
        return !(idx == 5'd1 || idx == 5'd2 || idx == 5'd9 || idx == 5'd16);
    endfunction

    state_t      state_q, state_d;
    logic [1:28] c_q, c_d, d_q, d_d;
    logic [3:0]  round_q, round_d;
    logic        mode_q, mode_d;
    logic [1:56] pc1_key;
    logic [4:0]  sched_idx;
    logic        two;

    assign pc1_key = pc1(key_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            mode_q  <= mode_d;
        end
    end

    // Decrypt walks the schedule backwards: transition r->r+1 undoes S[16-r].
    assign sched_idx = mode_q ? (5'd16 - {1'b0, round_q}) : ({1'b0, round_q} + 5'd2);
    assign two       = shift_two(sched_idx);

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    state_d = RUN;
                    mode_d  = decrypt;
                    round_d = '0;
                    // C0/D0 unrotated already equals C16/D16 (total shift is 28).
                    if (decrypt) begin
                        c_d = pc1_key[1:28];
                        d_d = pc1_key[29:56];
                    end else begin
                        c_d = rotl(pc1_key[1:28], 1'b0);
                        d_d = rotl(pc1_key[29:56], 1'b0);
                    end
                end
            end
            RUN: begin
                if (subkey_ready) begin
                    if (round_q == 4'd15) begin
                        state_d = IDLE;
                        round_d = '0;
                    end else begin
                        round_d = round_q + 4'd1;
                        c_d     = mode_q ? rotr(c_q, two) : rotl(c_q, two);
                        d_d     = mode_q ? rotr(d_q, two) : rotl(d_q, two);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        key_ready    = (state_q == IDLE);
        subkey_valid = (state_q == RUN);
        subkey       = pc2({c_q, d_q});
        subkey_round = round_q;
        subkey_last  = (state_q == RUN) && (round_q == 4'd15);
    end

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: stimulus pushes expected subkeys,
// a negedge monitor compares every presented subkey against the queue head.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:64] key_in;
    logic        decrypt;
    logic        key_valid;
    logic        key_ready;
    logic [1:48] subkey;
    logic [3:0]  subkey_round;
    logic        subkey_valid;
    logic        subkey_ready;
    logic        subkey_last;

    des_key_schedule dut (
        .clk(clk), .rst(rst), .key_in(key_in), .decrypt(decrypt),
        .key_valid(key_valid), .key_ready(key_ready), .subkey(subkey),
        .subkey_round(subkey_round), .subkey_valid(subkey_valid),
        .subkey_ready(subkey_ready), .subkey_last(subkey_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] k;
        logic [3:0]  rnd;
        logic        last;
    } exp_t;

    exp_t exp_q [$];
    int   n_vec = 0;
    int   n_err = 0;

    // K1..K16 for key 133457799BBCDFF1, worked by hand from the FIPS tables.
    localparam logic [47:0] HAND [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    localparam int TB_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int TB_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SCHED [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    logic [47:0] exp_k [16];

    // Kn straight from the definition: cumulative left rotation of PC-1(key), then PC-2.
    function automatic logic [47:0] model_k(input logic [63:0] key, input int n);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] k;
        int sh;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-TB_PC1[i]];
        c = cd[55:28];
        d = cd[27:0];
        sh = 0;
        for (int j = 0; j < n; j++) sh += SCHED[j];
        for (int j = 0; j < sh; j++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) k[47-i] = cd[56-TB_PC2[i]];
        return k;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && subkey_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_subkey_valid", 64'(subkey_valid), 64'd0);
            end else begin
                check("subkey", 64'(subkey), 64'(exp_q[0].k));
                check("subkey_round", 64'(subkey_round), 64'(exp_q[0].rnd));
                check("subkey_last", 64'(subkey_last), 64'(exp_q[0].last));
                if (subkey_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic load_hand();
        for (int i = 0; i < 16; i++) exp_k[i] = HAND[i];
    endtask

    task automatic load_model(input logic [63:0] key);
        for (int i = 0; i < 16; i++) exp_k[i] = model_k(key, i + 1);
    endtask

    task automatic accept_key(input logic [63:0] key, input logic dec);
        int cyc;
        exp_t e;
        cyc = 0;
        while (!key_ready && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        check("key_ready_before_accept", 64'(key_ready), 64'd1);
        key_in = key; decrypt = dec; key_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            e.k    = dec ? exp_k[15-i] : exp_k[i];
            e.rnd  = 4'(i);
            e.last = (i == 15);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        key_valid = 1'b0;
        key_in = '0; decrypt = ~dec;
    endtask

    // bp_round >= 0 stalls 5 cycles there; busy_round >= 0 pulses key_valid there.
    task automatic run_key(input logic [63:0] key, input logic dec,
                           input int bp_round, input int busy_round);
        int cyc;
        accept_key(key, dec);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            if (int'(subkey_round) == bp_round && subkey_valid) begin
                subkey_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 subkey_ready = 1'b1;
                bp_round = -1;
            end
            if (int'(subkey_round) == busy_round && subkey_valid) begin
                key_in = 64'hFFFF_0000_FFFF_0000; key_valid = 1'b1;
                @(posedge clk); #1 key_valid = 1'b0;
                busy_round = -1;
                cyc++;
                continue;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("run_completed_in_budget", 64'(exp_q.size()), 64'd0);
        check("key_ready_after_last", 64'(key_ready), 64'd1);
        check("valid_low_after_last", 64'(subkey_valid), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 check("no_second_run", 64'(subkey_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1; key_in = '0; decrypt = 1'b0; key_valid = 1'b0; subkey_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_key_ready", 64'(key_ready), 64'd1);
        check("reset_subkey_valid", 64'(subkey_valid), 64'd0);
        check("reset_subkey_round", 64'(subkey_round), 64'd0);
        check("reset_subkey", 64'(subkey), 64'd0);
        check("reset_subkey_last", 64'(subkey_last), 64'd0);

        load_hand();
        run_key(64'h133457799BBCDFF1, 1'b0, -1, -1);
        run_key(64'h133457799BBCDFF1, 1'b1, -1, -1);
        run_key(64'h133457799BBCDFF1, 1'b0, 3, -1);
        // Same key with every parity bit flipped, plus a stray key_valid while busy.
        run_key(64'h123556789ABDDEF0, 1'b0, -1, 5);

        load_model(64'h123456789ABCDEF0);
        run_key(64'h123456789ABCDEF0, 1'b0, -1, -1);
        run_key(64'h133557799BBDDFF1, 1'b1, -1, -1);

        // Abandon a run at round 7 with a reset.
        load_hand();
        accept_key(64'h133457799BBCDFF1, 1'b0);
        for (int c = 0; c < 40 && !(subkey_valid && subkey_round == 4'd7); c++) begin
            @(posedge clk); #1;
        end
        check("reached_round7", 64'(subkey_round), 64'd7);
        subkey_ready = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        rst = 1'b0; subkey_ready = 1'b1;
        check("midrst_key_ready", 64'(key_ready), 64'd1);
        check("midrst_subkey_valid", 64'(subkey_valid), 64'd0);
        check("midrst_subkey_round", 64'(subkey_round), 64'd0);
        check("midrst_subkey", 64'(subkey), 64'd0);
        run_key(64'h133457799BBCDFF1, 1'b0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
